ib_mul_8x8_s0_l16: RTL and testbench
====================================

# ib_mul_8x8_s0_l16

Sequential unsigned 8x8-bit multiplier producing a 16-bit product with a fixed 16-cycle latency. It uses a start/done handshake and a shift-add datapath: one partial-product add and one shift per multiplier bit. It is a small arithmetic benchmark block, used standalone or behind a controller that issues one multiplication at a time.

## Interface
- No parameters; widths fixed (A/B 8 bits, C 16 bits, latency 16).
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_start  input  1  start request; sampled each rising edge.
- i_a  input  8  multiplicand, unsigned; sampled when start accepted.
- i_b  input  8  multiplier, unsigned; sampled when start accepted.
- o_c  output  16  product i_a*i_b; registered; valid while o_done=1.
- o_done  output  1  result-valid flag; level, held until next accepted start.

## Operation
- States: IDLE, ADD, SHIFT. Registers:
  - mcand[15:0]
  - mult[7:0]
  - acc[15:0]
  - cnt[2:0]
  - o_c[15:0]
  - o_done
- Reset (i_rst=1 at an edge):
  - state=IDLE; o_c=0; o_done=0; acc, mcand, mult and cnt cleared.
  - Reset overrides everything, including mid-operation; no partial result is ever presented.
- IDLE with i_start=1 (accept):
  - Load mcand={8'h00,i_a}, mult=i_b, acc=0, cnt=0.
  - Clear o_done; go to ADD.
  - o_c keeps its old value until completion.
- ADD: if mult[0]=1 then acc=acc+mcand (16-bit, cannot overflow); go to SHIFT.
- SHIFT:
  - mcand=mcand<<1, mult=mult>>1, cnt=cnt+1.
  - If cnt was 7: o_c=acc, o_done=1, go to IDLE. Otherwise go to ADD.
- i_start while in ADD/SHIFT is ignored (default build).
- i_a/i_b changes after acceptance have no effect.
- Arithmetic is unsigned only; 255*255=65025 (0xFE01) is the maximum.

## Timing
- Edge E0 samples i_start=1 in IDLE; o_done is low immediately after E0.
- ADD/SHIFT occupy edges E1..E16. o_done=1 and o_c valid immediately after E16: latency 16 cycles.
- o_done and o_c hold indefinitely until the next accepted start or reset.
- Back-to-back: a start sampled on the edge after completion (IDLE) is accepted; throughput is 1 result per 17 cycles minimum.
- i_start held high continuously starts a new operation on every IDLE edge. The caller deasserts it after one cycle.
- o_done deasserts on the same edge that accepts a new start. A caller polling o_done after issuing start never sees a stale result.

## Configuration
- Macro IB_MUL_RESTART_EN.
- Defined: i_start=1 in ADD or SHIFT aborts the current operation and restarts exactly as an IDLE accept. Operands are reloaded, cnt=0, o_done stays 0, and latency counts from the restarting edge.
- Undefined (default): i_start ignored while busy, as in Operation.

## Structure
- Package ib_mul_pkg holds:
  - constants IB_MUL_AW=8, IB_MUL_BW=8, IB_MUL_CW=16, IB_MUL_LAT=16;
  - state enum typedef ib_mul_state_t {IDLE, ADD, SHIFT}.
- One sub-module is natural: ib_mul_step, a combinational conditional add (acc + (bit ? mcand : 0)) used in the ADD state.
- The top module holds the FSM, counter and registers.

## Test plan
- Reset: assert i_rst 2 cycles mid-operation -> o_done=0, o_c=0, state IDLE; the next start completes normally.
- Single op: a=0x0D, b=0x0B, 1-cycle start -> o_done rises exactly 16 edges later, o_c=0x008F. Also 0*x=0 and x*0=0.
- Extremes: a=0xFF, b=0xFF -> o_c=0xFE01. Also a=0x80, b=0x02 -> o_c=0x0100.
- Exhaustive: all 65536 (a,b) pairs, each with a 1-cycle start, wait for o_done -> o_c==a*b every time. No o_done before 16 cycles.
- Handshake: start on the first edge after done -> o_done drops on that edge, result after 16 more. Changing i_a/i_b mid-op leaves the result unchanged. Start pulses while busy are ignored (default).
- IB_MUL_RESTART_EN: start 3*5, then restart at cycle 6 with 7*9 -> o_done 16 cycles after the restart, o_c=0x003F, with no intermediate done.

Source files
------------

// File: rtl/ib_mul_pkg.sv
// Shared widths, state encoding and helpers for the sequential 8x8 shift-add multiplier.
// Optional feature macro used by the top: IB_MUL_RESTART_EN.
package ib_mul_pkg;

  localparam int unsigned IB_MUL_AW   = 8;
  localparam int unsigned IB_MUL_BW   = 8;
  localparam int unsigned IB_MUL_CW   = 16;
  localparam int unsigned IB_MUL_LAT  = 16;
  localparam int unsigned IB_MUL_CNTW = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2
  } ib_mul_state_t;

  // True on the SHIFT that retires the final multiplier bit.
  function automatic logic ib_mul_last(input logic [IB_MUL_CNTW-1:0] cnt);
    return cnt == {IB_MUL_CNTW{1'b1}};
  endfunction

endpackage

// File: rtl/ib_mul_step.sv
// One partial-product step: conditionally add the shifted multiplicand into the accumulator.
module ib_mul_step
  import ib_mul_pkg::*;
(
  input  logic [IB_MUL_CW-1:0] i_acc,
  input  logic [IB_MUL_CW-1:0] i_mcand,
  input  logic                 i_bit,
  output logic [IB_MUL_CW-1:0] o_sum
);

  logic [IB_MUL_CW-1:0] w_addend;

  assign w_addend = i_bit ? i_mcand : '0;
  // Unsigned 8x8 partial sums never exceed 16 bits, so no carry-out is needed.
  assign o_sum    = i_acc + w_addend;

endmodule

// File: rtl/ib_mul_8x8_s0_l16.sv
// Sequential unsigned 8x8 multiplier, 16-cycle latency, start/done handshake.
// Define IB_MUL_RESTART_EN to let i_start abort and restart a busy operation.
module ib_mul_8x8_s0_l16
  import ib_mul_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [IB_MUL_AW-1:0] i_a,
  input  logic [IB_MUL_BW-1:0] i_b,
  output logic [IB_MUL_CW-1:0] o_c,
  output logic                 o_done
);

  ib_mul_state_t          r_state;
  logic [IB_MUL_CW-1:0]   r_mcand;
  logic [IB_MUL_BW-1:0]   r_mult;
  logic [IB_MUL_CW-1:0]   r_acc;
  logic [IB_MUL_CNTW-1:0] r_cnt;
  logic [IB_MUL_CW-1:0]   r_c;
  logic                   r_done;

  logic                   w_accept;
  logic [IB_MUL_CW-1:0]   w_sum;

`ifdef IB_MUL_RESTART_EN
  assign w_accept = i_start;
`else
  assign w_accept = i_start && (r_state == IDLE);
`endif

  ib_mul_step u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mult[0]),
    .o_sum   (w_sum)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_mult  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= '0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      // r_c is left alone so the previous result stays visible until completion.
      r_state <= ADD;
      r_mcand <= {{(IB_MUL_CW - IB_MUL_AW){1'b0}}, i_a};
      r_mult  <= i_b;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        ADD: begin
          r_acc   <= w_sum;
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (ib_mul_last(r_cnt)) begin
            r_c     <= r_acc;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_state <= ADD;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_c    = r_c;
  assign o_done = r_done;

endmodule

// File: tb/tb_ib_mul_8x8_s0_l16.sv
// Self-checking bench for ib_mul_8x8_s0_l16: directed and randomized ops against a*b.
module tb_ib_mul_8x8_s0_l16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] c;
  logic        done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] prev_c   = 16'h0;

  always #5 clk = ~clk;

  ib_mul_8x8_s0_l16 dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_c     (c),
    .o_done  (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op; optionally scramble operands and pulse start while busy.
  task automatic do_op(input logic [7:0] opa, input logic [7:0] opb,
                       input bit scramble, input bit busy_pulse, input string tag);
    int   cyc;
    logic [15:0] exp_c;
    exp_c = 16'(opa) * 16'(opb);
    a     = opa;
    b     = opb;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_done_low_after_accept"}, {31'd0, done}, 32'd0);
    check({tag, "_c_held_after_accept"}, {16'd0, c}, {16'd0, prev_c});
    cyc = 0;
    while (cyc < 40) begin
      if (scramble) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
`ifndef IB_MUL_RESTART_EN
      if (busy_pulse && (cyc == 5 || cyc == 10)) start = 1'b1;
`endif
      tick();
      start = 1'b0;
      cyc++;
      if (done) break;
    end
    check({tag, "_latency"}, cyc, 32'd16);
    check({tag, "_product"}, {16'd0, c}, {16'd0, exp_c});
    prev_c = exp_c;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h0;
    b     = 8'h0;
    tick();
    tick();
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_c", {16'd0, c}, 32'd0);
    rst = 1'b0;
    tick();

    do_op(8'h0D, 8'h0B, 1'b0, 1'b0, "single_0d_0b");
    check("single_value", {16'd0, c}, 32'h008F);
    // Result and flag must hold while idle.
    for (int i = 0; i < 5; i++) tick();
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_c", {16'd0, c}, 32'h008F);

    do_op(8'h00, 8'h5A, 1'b0, 1'b0, "zero_a");
    do_op(8'hA5, 8'h00, 1'b0, 1'b0, "zero_b");
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0, "max");
    check("max_value", {16'd0, c}, 32'hFE01);
    do_op(8'h80, 8'h02, 1'b0, 1'b0, "pow2");
    check("pow2_value", {16'd0, c}, 32'h0100);

    // Back-to-back: start driven right after done is seen, accepted on the next edge.
    do_op(8'h12, 8'h34, 1'b1, 1'b0, "scramble");
    do_op(8'hC3, 8'h7E, 1'b0, 1'b1, "busy_pulse");

    // Reset mid-operation.
    a     = 8'h77;
    b     = 8'h99;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_c", {16'd0, c}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("midrst_no_done", {31'd0, done}, 32'd0);
    end
    prev_c = 16'h0;
    do_op(8'h77, 8'h99, 1'b0, 1'b0, "after_rst");

`ifdef IB_MUL_RESTART_EN
    begin
      int cyc;
      a     = 8'd3;
      b     = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      a     = 8'd7;
      b     = 8'd9;
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 0;
      while (cyc < 40) begin
        tick();
        cyc++;
        if (done) break;
      end
      check("restart_latency", cyc, 32'd16);
      check("restart_product", {16'd0, c}, 32'h003F);
      prev_c = 16'h003F;
    end
`endif

    for (int n = 0; n < 300; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (n % 7 == 0) ra = 8'hFF;
      if (n % 11 == 0) rb = 8'hFF;
      do_op(ra, rb, (n % 3 == 0), (n % 5 == 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
